// File: rtl/procyon_mhq_ex.sv
// Miss handling queue execute stage: allocates and merges store data into
// queue entries, presents the head entry to the CCU and retires it on done.
module procyon_mhq_ex #(
  parameter int unsigned OPTN_DATA_WIDTH   = 32,
  parameter int unsigned OPTN_ADDR_WIDTH   = 32,
  parameter int unsigned OPTN_MHQ_DEPTH    = 4,
  parameter int unsigned OPTN_DC_LINE_SIZE = 32,
  localparam int unsigned MHQ_IDX_WIDTH    = $clog2(OPTN_MHQ_DEPTH),
  localparam int unsigned DC_OFFSET_WIDTH  = $clog2(OPTN_DC_LINE_SIZE),
  localparam int unsigned DC_LINE_WIDTH    = OPTN_DC_LINE_SIZE * 8,
  localparam int unsigned WORD_SIZE        = OPTN_DATA_WIDTH / 8,
  localparam int unsigned LINE_ADDR_WIDTH  = OPTN_ADDR_WIDTH - DC_OFFSET_WIDTH,
  localparam int unsigned PTR_WIDTH        = MHQ_IDX_WIDTH + 1
) (
  input  logic                                            clk,
  input  logic                                            n_rst,
  input  logic                                            i_mhq_lu_en,
  input  logic                                            i_mhq_lu_we,
  input  logic [DC_OFFSET_WIDTH-1:0]                      i_mhq_lu_offset,
  input  logic [OPTN_DATA_WIDTH-1:0]                      i_mhq_lu_wr_data,
  input  logic [WORD_SIZE-1:0]                            i_mhq_lu_byte_select,
  input  logic                                            i_mhq_lu_match,
  input  logic [MHQ_IDX_WIDTH-1:0]                        i_mhq_lu_tag,
  input  logic [LINE_ADDR_WIDTH-1:0]                      i_mhq_lu_addr,
  input  logic                                            i_ccu_done,
  output logic [PTR_WIDTH-1:0]                            o_mhq_tail_next,
  output logic [PTR_WIDTH-1:0]                            o_mhq_head_next,
  output logic [OPTN_MHQ_DEPTH-1:0]                       o_mhq_entry_valid,
  output logic [OPTN_MHQ_DEPTH-1:0][LINE_ADDR_WIDTH-1:0]  o_mhq_entry_addr,
  output logic                                            o_mhq_ex_bypass_en,
  output logic                                            o_mhq_ex_bypass_we,
  output logic                                            o_mhq_ex_bypass_match,
  output logic [LINE_ADDR_WIDTH-1:0]                      o_mhq_ex_bypass_addr,
  output logic [MHQ_IDX_WIDTH-1:0]                        o_mhq_ex_bypass_tag,
  output logic                                            o_ccu_en,
  output logic                                            o_ccu_we,
  output logic [OPTN_ADDR_WIDTH-1:0]                      o_ccu_addr,
  output logic [DC_LINE_WIDTH-1:0]                        o_ccu_data,
  output logic [OPTN_DC_LINE_SIZE-1:0]                    o_ccu_byte_mask
);

  // Wide enough to hold offset + word byte index without overflow
  localparam int unsigned BIDX_WIDTH = $clog2(OPTN_DC_LINE_SIZE + WORD_SIZE);

  logic [PTR_WIDTH-1:0]                                 head;
  logic [PTR_WIDTH-1:0]                                 tail;
  logic [OPTN_MHQ_DEPTH-1:0]                            entry_valid;
  logic [OPTN_MHQ_DEPTH-1:0]                            entry_dirty;
  logic [OPTN_MHQ_DEPTH-1:0][LINE_ADDR_WIDTH-1:0]       entry_addr;
  logic [OPTN_MHQ_DEPTH-1:0][DC_LINE_WIDTH-1:0]         entry_data;
  logic [OPTN_MHQ_DEPTH-1:0][OPTN_DC_LINE_SIZE-1:0]     entry_mask;

  logic [MHQ_IDX_WIDTH-1:0]     head_idx;
  logic                         full;
  logic                         alloc;
  logic                         merge_st;
  logic                         dequeue;
  logic [DC_LINE_WIDTH-1:0]     merge_data;
  logic [OPTN_DC_LINE_SIZE-1:0] merge_mask;

  // Queue control: full when pointers differ only in the wrap bit
  always_comb begin
    head_idx = head[MHQ_IDX_WIDTH-1:0];
    full     = ({~tail[MHQ_IDX_WIDTH], tail[MHQ_IDX_WIDTH-1:0]} == head);
    alloc    = i_mhq_lu_en & ~i_mhq_lu_match & ~full;
    merge_st = i_mhq_lu_en & i_mhq_lu_match & i_mhq_lu_we;
    dequeue  = i_ccu_done & entry_valid[head_idx];
  end

  // Byte merge of the store word into the target line; overhanging bytes drop
  always_comb begin
    merge_data = alloc ? '0 : entry_data[i_mhq_lu_tag];
    merge_mask = alloc ? '0 : entry_mask[i_mhq_lu_tag];
    for (int j = 0; j < int'(OPTN_DC_LINE_SIZE); j++) begin
      for (int b = 0; b < int'(WORD_SIZE); b++) begin
        if (i_mhq_lu_byte_select[b] &&
            ((BIDX_WIDTH'(i_mhq_lu_offset) + BIDX_WIDTH'(b)) == BIDX_WIDTH'(j))) begin
          merge_data[j*8 +: 8] = i_mhq_lu_wr_data[b*8 +: 8];
          merge_mask[j]        = 1'b1;
        end
      end
    end
  end

  // Entry and pointer state; dequeue is applied last so it wins over a merge
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      head        <= '0;
      tail        <= '0;
      entry_valid <= '0;
      entry_dirty <= '0;
      entry_mask  <= '0;
    end else begin
      head <= o_mhq_head_next;
      tail <= o_mhq_tail_next;
      if (alloc || merge_st) begin
        entry_data[i_mhq_lu_tag]  <= merge_data;
        entry_mask[i_mhq_lu_tag]  <= merge_mask;
        entry_dirty[i_mhq_lu_tag] <= alloc ? i_mhq_lu_we : 1'b1;
      end
      if (alloc) begin
        entry_valid[i_mhq_lu_tag] <= 1'b1;
        entry_addr[i_mhq_lu_tag]  <= i_mhq_lu_addr;
      end
      if (dequeue) begin
        entry_valid[head_idx] <= 1'b0;
        entry_dirty[head_idx] <= 1'b0;
        entry_mask[head_idx]  <= '0;
      end
    end
  end

  // Next-cycle pointers and zero-latency bypass of the current request
  always_comb begin
    o_mhq_tail_next       = tail + PTR_WIDTH'(alloc);
    o_mhq_head_next       = head + PTR_WIDTH'(dequeue);
    o_mhq_ex_bypass_en    = i_mhq_lu_en & ~i_mhq_lu_match;
    o_mhq_ex_bypass_we    = i_mhq_lu_en & i_mhq_lu_we;
    o_mhq_ex_bypass_match = i_mhq_lu_match;
    o_mhq_ex_bypass_addr  = i_mhq_lu_addr;
    o_mhq_ex_bypass_tag   = i_mhq_lu_tag;
  end

  // Registered entry feedback and head-entry request to the CCU
  always_comb begin
    o_mhq_entry_valid = entry_valid;
    o_mhq_entry_addr  = entry_addr;
    o_ccu_en          = entry_valid[head_idx];
    o_ccu_we          = entry_dirty[head_idx];
    o_ccu_addr        = {entry_addr[head_idx], {DC_OFFSET_WIDTH{1'b0}}};
    o_ccu_data        = entry_data[head_idx];
    o_ccu_byte_mask   = entry_mask[head_idx];
  end

endmodule

// File: tb/tb_procyon_mhq_ex.sv
// Randomized bench for procyon_mhq_ex against a byte-level queue model.
module tb_procyon_mhq_ex;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int LINE  = 32;
  localparam int IDXW  = 2;
  localparam int OFFW  = 5;
  localparam int LAW   = AW - OFFW;
  localparam int WS    = DW / 8;
  localparam int LW    = LINE * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          n_rst;
  logic                          en, we, match, done;
  logic [OFFW-1:0]               off;
  logic [DW-1:0]                 wdata;
  logic [WS-1:0]                 sel;
  logic [IDXW-1:0]               tag;
  logic [LAW-1:0]                laddr;
  logic [IDXW:0]                 tail_next, head_next;
  logic [DEPTH-1:0]              entry_valid;
  logic [DEPTH-1:0][LAW-1:0]     entry_addr;
  logic                          byp_en, byp_we, byp_match;
  logic [LAW-1:0]                byp_addr;
  logic [IDXW-1:0]               byp_tag;
  logic                          ccu_en, ccu_we;
  logic [AW-1:0]                 ccu_addr;
  logic [LW-1:0]                 ccu_data;
  logic [LINE-1:0]               ccu_mask;

  procyon_mhq_ex dut (
    .clk                   (clk),
    .n_rst                 (n_rst),
    .i_mhq_lu_en           (en),
    .i_mhq_lu_we           (we),
    .i_mhq_lu_offset       (off),
    .i_mhq_lu_wr_data      (wdata),
    .i_mhq_lu_byte_select  (sel),
    .i_mhq_lu_match        (match),
    .i_mhq_lu_tag          (tag),
    .i_mhq_lu_addr         (laddr),
    .i_ccu_done            (done),
    .o_mhq_tail_next       (tail_next),
    .o_mhq_head_next       (head_next),
    .o_mhq_entry_valid     (entry_valid),
    .o_mhq_entry_addr      (entry_addr),
    .o_mhq_ex_bypass_en    (byp_en),
    .o_mhq_ex_bypass_we    (byp_we),
    .o_mhq_ex_bypass_match (byp_match),
    .o_mhq_ex_bypass_addr  (byp_addr),
    .o_mhq_ex_bypass_tag   (byp_tag),
    .o_ccu_en              (ccu_en),
    .o_ccu_we              (ccu_we),
    .o_ccu_addr            (ccu_addr),
    .o_ccu_data            (ccu_data),
    .o_ccu_byte_mask       (ccu_mask)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference model: queue of line buffers indexed by tag, free-running pointers mod 2*DEPTH
  bit             m_valid [DEPTH];
  bit             m_dirty [DEPTH];
  logic [LAW-1:0] m_addr  [DEPTH];
  logic [7:0]     m_data  [DEPTH][LINE];
  bit             m_mask  [DEPTH][LINE];
  int             m_head;
  int             m_tail;

  function automatic bit m_full();
    return ((m_tail - m_head) & (2 * DEPTH - 1)) == DEPTH;
  endfunction

  function automatic bit m_alloc();
    return en && !match && !m_full();
  endfunction

  function automatic bit m_deq();
    return done && m_valid[m_head % DEPTH];
  endfunction

  task automatic m_merge(input int t);
    for (int b = 0; b < WS; b++) begin
      if (sel[b] && (int'(off) + b) < LINE) begin
        m_data[t][int'(off) + b] = wdata[8*b +: 8];
        m_mask[t][int'(off) + b] = 1'b1;
      end
    end
  endtask

  task automatic model_edge();
    bit a, d;
    int t;
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 0;
        m_dirty[i] = 0;
        for (int j = 0; j < LINE; j++) m_mask[i][j] = 0;
      end
      m_head = 0;
      m_tail = 0;
      return;
    end
    a = m_alloc();
    d = m_deq();
    t = int'(tag);
    if (a) begin
      m_valid[t] = 1;
      m_addr[t]  = laddr;
      m_dirty[t] = we;
      for (int j = 0; j < LINE; j++) begin
        m_data[t][j] = 8'h00;
        m_mask[t][j] = 0;
      end
      m_merge(t);
    end else if (en && match && we) begin
      m_merge(t);
      m_dirty[t] = 1;
    end
    if (d) begin
      m_valid[m_head % DEPTH] = 0;
      m_dirty[m_head % DEPTH] = 0;
      for (int j = 0; j < LINE; j++) m_mask[m_head % DEPTH][j] = 0;
    end
    m_tail = (m_tail + int'(a)) % (2 * DEPTH);
    m_head = (m_head + int'(d)) % (2 * DEPTH);
  endtask

  task automatic check_comb();
    check("tail_next", 256'(tail_next), 256'((m_tail + int'(m_alloc())) % (2 * DEPTH)));
    check("head_next", 256'(head_next), 256'((m_head + int'(m_deq())) % (2 * DEPTH)));
    check("bypass_en", 256'(byp_en), 256'(en && !match));
    check("bypass_we", 256'(byp_we), 256'(en && we));
    check("bypass_match", 256'(byp_match), 256'(match));
    check("bypass_addr", 256'(byp_addr), 256'(laddr));
    check("bypass_tag", 256'(byp_tag), 256'(tag));
  endtask

  task automatic check_state();
    logic [DEPTH-1:0] v;
    logic [LINE-1:0]  mk;
    logic [LW-1:0]    dt;
    int h;
    h = m_head % DEPTH;
    for (int i = 0; i < DEPTH; i++) v[i] = m_valid[i];
    for (int j = 0; j < LINE; j++) begin
      mk[j]         = m_mask[h][j];
      dt[8*j +: 8]  = m_data[h][j];
    end
    check("entry_valid", 256'(entry_valid), 256'(v));
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i]) check("entry_addr", 256'(entry_addr[i]), 256'(m_addr[i]));
    check("ccu_en", 256'(ccu_en), 256'(m_valid[h]));
    check("ccu_we", 256'(ccu_we), 256'(m_dirty[h]));
    check("ccu_mask", 256'(ccu_mask), 256'(mk));
    if (m_valid[h]) begin
      check("ccu_addr", 256'(ccu_addr), 256'({m_addr[h], 5'b00000}));
      check("ccu_data", 256'(ccu_data), 256'(dt));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_state();
  endtask

  task automatic drive(input bit en_, input bit we_, input bit match_, input logic [IDXW-1:0] tag_,
                       input logic [LAW-1:0] addr_, input logic [OFFW-1:0] off_,
                       input logic [WS-1:0] sel_, input logic [DW-1:0] data_, input bit done_);
    en    = en_;
    we    = we_;
    match = match_;
    tag   = tag_;
    laddr = addr_;
    off   = off_;
    sel   = sel_;
    wdata = data_;
    done  = done_;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, '0, '0, '0, 0);
  endtask

  initial begin
    logic [IDXW-1:0] rtag;
    m_head = 0;
    m_tail = 0;
    idle();
    n_rst = 1'b0;
    cycle();
    cycle();
    n_rst = 1'b1;
    check("rst_ccu_en", 256'(ccu_en), 256'(0));
    check("rst_ccu_we", 256'(ccu_we), 256'(0));
    check("rst_ccu_mask", 256'(ccu_mask), 256'(0));
    check("rst_valid", 256'(entry_valid), 256'(0));
    check("rst_tail_next", 256'(tail_next), 256'(0));
    check("rst_head_next", 256'(head_next), 256'(0));

    // Store allocation into entry 0
    drive(1, 1, 0, 2'd0, 27'h40, 5'd4, 4'hF, 32'hAABBCCDD, 0);
    cycle();
    idle();
    #1;
    check("alloc_ccu_en", 256'(ccu_en), 256'(1));
    check("alloc_ccu_addr", 256'(ccu_addr), 256'(32'h800));
    check("alloc_mask", 256'(ccu_mask), 256'(32'h000000F0));
    check("alloc_bytes", 256'(ccu_data[63:32]), 256'(32'hAABBCCDD));
    check("alloc_tail_next", 256'(tail_next), 256'(1));

    // Matching store merges a single byte
    drive(1, 1, 1, 2'd0, 27'h40, 5'd5, 4'h1, 32'h00000011, 0);
    cycle();
    idle();
    #1;
    check("merge_bytes", 256'(ccu_data[63:32]), 256'(32'hAABB11DD));
    check("merge_mask", 256'(ccu_mask), 256'(32'h000000F0));
    check("merge_tail_next", 256'(tail_next), 256'(1));

    // Fill the queue, then an extra allocation is dropped
    for (int i = 1; i < DEPTH; i++) begin
      drive(1, 1, 0, IDXW'(i), LAW'(27'h100 + i), 5'd0, 4'hF, $urandom, 0);
      cycle();
    end
    drive(1, 1, 0, 2'd0, 27'h1FF, 5'd0, 4'hF, 32'h12345678, 0);
    #1;
    check("full_tail_next", 256'(tail_next), 256'(4));
    cycle();
    check("full_valid", 256'(entry_valid), 256'(4'hF));
    check("full_addr0", 256'(entry_addr[0]), 256'(27'h40));

    // Dequeue with an allocation attempt while full; allocation lands next cycle
    drive(1, 0, 0, 2'd0, 27'h200, 5'd0, 4'h0, 32'h0, 1);
    #1;
    check("wrap_head_next", 256'(head_next), 256'(1));
    check("wrap_tail_next_full", 256'(tail_next), 256'(4));
    cycle();
    drive(1, 0, 0, 2'd0, 27'h200, 5'd0, 4'h0, 32'h0, 0);
    cycle();
    idle();
    #1;
    check("wrap_tail", 256'(tail_next), 256'(5));
    check("wrap_head", 256'(head_next), 256'(1));
    check("wrap_count", 256'($countones(entry_valid)), 256'(4));
    check("wrap_addr0", 256'(entry_addr[0]), 256'(27'h200));

    // Drain everything
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, '0, '0, '0, '0, '0, 1);
      cycle();
    end
    check("drain_ccu_en", 256'(ccu_en), 256'(0));

    // Store overhanging the end of the line keeps only the last two bytes
    drive(1, 1, 0, 2'd1, 27'h3AB, 5'd30, 4'hF, 32'h12345678, 0);
    cycle();
    idle();
    #1;
    check("edge_mask", 256'(ccu_mask), 256'(32'hC0000000));
    check("edge_hi", 256'(ccu_data[255:240]), 256'(16'h5678));
    check("edge_lo", 256'(ccu_data[239:0]), 256'(0));
    check("edge_addr", 256'(ccu_addr), 256'(32'h7560));

    // Merge into the head entry loses to a same-cycle dequeue
    drive(1, 1, 1, 2'd1, 27'h3AB, 5'd0, 4'hF, 32'hDEADBEEF, 1);
    cycle();
    check("mdq_ccu_en", 256'(ccu_en), 256'(0));
    check("mdq_valid", 256'(entry_valid), 256'(0));

    // Reset with three live entries and a request in flight
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, IDXW'(m_tail % DEPTH), LAW'($urandom), OFFW'($urandom), WS'($urandom), $urandom, 0);
      cycle();
    end
    check("pre_rst_count", 256'($countones(entry_valid)), 256'(3));
    drive(1, 1, 0, IDXW'(m_tail % DEPTH), 27'h55, 5'd0, 4'hF, 32'h1, 0);
    n_rst = 1'b0;
    cycle();
    n_rst = 1'b1;
    idle();
    #1;
    check("mrst_valid", 256'(entry_valid), 256'(0));
    check("mrst_ccu_en", 256'(ccu_en), 256'(0));
    check("mrst_tail_next", 256'(tail_next), 256'(0));
    check("mrst_head_next", 256'(head_next), 256'(0));

    // Randomized traffic
    for (int it = 0; it < 800; it++) begin
      n_rst = ($urandom % 60) != 0;
      match = ($urandom % 3) == 0;
      rtag  = match ? IDXW'($urandom) : IDXW'(m_tail % DEPTH);
      drive(($urandom % 4) != 0, $urandom % 2 == 1, match, rtag, LAW'($urandom),
            OFFW'($urandom), WS'($urandom), $urandom, ($urandom % 3) == 0);
      cycle();
    end
    n_rst = 1'b1;
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
